alu_sweeper: RTL and testbench
==============================

ALU_SWEEPER -- requirements
Module: alu_sweeper

Interface
REQ-001 SHALL have parameter DWELL, default 2, meaning cycles each opcode is held on alu_sel before alu_op is sampled (legal 1..15).
REQ-002 SHALL have parameter SKIP_MASK, default 16'h0000, meaning bit n set = opcode n is skipped.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  request one sweep; sampled only in IDLE.
REQ-006 a_in, b_in  input  4 each  operands, latched on accepted start.
REQ-007 exp_sig  input  16  expected signature, compared at sweep end.
REQ-008 alu_a, alu_b  output  4 each  operands driven to the ALU (latched values).
REQ-009 alu_sel  output  4  opcode driven to the ALU.
REQ-010 alu_op  input  16  ALU result, treated as combinational from alu_a/alu_b/alu_sel.
REQ-011 busy  output  1  high while a sweep is in progress (RUN or FIN).
REQ-012 done  output  1  one-cycle pulse at sweep end.
REQ-013 pass  output  1  1 = final signature equalled exp_sig; held until next accepted start.
REQ-014 signature  output  16  running result signature.
REQ-015 rd_addr  input  4 / rd_data  output  16  combinational readback of captured result for opcode rd_addr.

Function
REQ-016 States SHALL be IDLE, RUN, FIN; IDLE->RUN on start=1; RUN->FIN after opcode 15 processed; FIN->IDLE unconditionally after one cycle.
REQ-017 Accepted start SHALL latch a_in/b_in, clear signature, pass, all 16 result entries, and the dwell counter, and set alu_sel=0 from the next cycle.
REQ-018 start while busy SHALL be ignored; no restart, no state change.
REQ-019 For a non-skipped opcode, alu_sel SHALL be held for exactly DWELL cycles; on the edge ending the last cycle, result[alu_sel] <= alu_op and signature <= {signature[14:0],signature[15]} ^ alu_op.
REQ-020 A skipped opcode SHALL occupy exactly 1 cycle on alu_sel, leave result entry 0, and not update signature.
REQ-021 alu_sel SHALL increment by 1 after each opcode; no wrap: after 15, FSM goes to FIN and alu_sel returns to 0.
REQ-022 Sweep with no skips SHALL take 16*DWELL RUN cycles; done SHALL be high in the single FIN cycle immediately following.
REQ-023 pass SHALL be updated in the FIN cycle (signature == exp_sig, exp_sig sampled that cycle) and visible with done.
REQ-024 alu_a/alu_b SHALL hold latched operands in all states; a_in/b_in changes mid-sweep SHALL have no effect.
REQ-025 rd_data SHALL reflect result[rd_addr] in any state, including partial results mid-sweep.
REQ-026 SKIP_MASK=16'hFFFF SHALL give a 16-cycle sweep, signature 0, all results 0.

Reset
REQ-027 rst=1 at any clock edge SHALL force IDLE and: alu_a=alu_b=alu_sel=0, busy=0, done=0, pass=0, signature=0, all results 0, dwell counter 0; rst has priority over start.
REQ-028 rst asserted mid-sweep SHALL abort without a done pulse; a start after rst releases SHALL begin a fresh sweep at opcode 0.

Verification (bench ALU model: op = {alu_sel, alu_a, alu_b, alu_a ^ alu_b}; bench computes expected signature with the REQ-019 formula)
REQ-029 DWELL=2, a=4'hD, b=4'h3, start 1 cycle -> alu_sel 0..15 each 2 cycles, done after 32 RUN cycles, result[5]=16'h5D3E, result[15]=16'hFD3E, pass=1 with matching exp_sig.
REQ-030 Same sweep with exp_sig = correct ^ 16'h0001 -> done pulse, pass=0, signature unchanged from REQ-029 value.
REQ-031 SKIP_MASK=16'h0010, DWELL=2 -> opcode 4 held 1 cycle, result[4]=0, sweep length 31 RUN cycles, signature excludes opcode 4 term.
REQ-032 start re-pulsed at RUN cycle 7 and a_in changed to 4'h0 -> no restart, alu_a stays 4'hD, results identical to REQ-029.
REQ-033 rst asserted at RUN cycle 10 -> next cycle busy=0, alu_sel=0, signature=0, rd_data=0 for all addresses, no done; following start completes normally.
REQ-034 rst and start both high same edge -> IDLE held, busy=0.

Source files
------------

// File: rtl/alu_sweeper_if.sv
// Bus bundle between the ALU sweeper and its environment: control
// handshake, operand/opcode drive to the ALU, ALU result return and the
// result readback port.
interface alu_sweeper_if;
  logic        start;
  logic [3:0]  a_in;
  logic [3:0]  b_in;
  logic [15:0] exp_sig;
  logic [3:0]  alu_a;
  logic [3:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [15:0] alu_op;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;

  // Environment side: requests sweeps, models the ALU, reads results.
  modport master (
    output start, a_in, b_in, exp_sig, alu_op, rd_addr,
    input  alu_a, alu_b, alu_sel, busy, done, pass, signature, rd_data
  );

  // Sweeper side.
  modport slave (
    input  start, a_in, b_in, exp_sig, alu_op, rd_addr,
    output alu_a, alu_b, alu_sel, busy, done, pass, signature, rd_data
  );
endinterface

// File: rtl/alu_sweeper.sv
// ALU sweeper: on start, latches two operands and steps the ALU opcode
// through 0..15, holding each opcode DWELL cycles (one cycle if masked
// off by SKIP_MASK). Each non-skipped result is captured into a 16-entry
// table and folded into a rotate-xor signature, which is compared
// against exp_sig when the sweep ends.
module alu_sweeper #(
  parameter int unsigned DWELL     = 2,        // 1..15
  parameter logic [15:0] SKIP_MASK = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  alu_sweeper_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [3:0]  sel_q, sel_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [15:0] sig_q, sig_d;
  logic        pass_q, pass_d;
  logic [15:0] result_q [16];
  logic [15:0] result_d [16];

  logic        skip_cur;
  logic        last_beat;
  logic [15:0] sig_next;
  logic        sig_match;

  // Per-opcode decode: is this opcode skipped, is this its final cycle,
  // and what the signature becomes if the current result is folded in.
  always_comb begin
    skip_cur  = SKIP_MASK[sel_q];
    last_beat = skip_cur || (dwell_q == DWELL_LAST);
    sig_next  = {sig_q[14:0], sig_q[15]} ^ bus.alu_op;
    sig_match = (sig_q == bus.exp_sig);
  end

  // Next-state and datapath next values.
  // NOTE: every _d gets a default from its _q first, so branches that do
  // not mention a signal simply hold it and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    dwell_d  = dwell_q;
    sig_d    = sig_q;
    pass_d   = pass_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          sel_d   = 4'd0;
          dwell_d = 4'd0;
          sig_d   = 16'h0000;
          pass_d  = 1'b0;
          for (int i = 0; i < 16; i++) result_d[i] = 16'h0000;
        end
      end

      RUN: begin
        if (last_beat) begin
          dwell_d = 4'd0;
          if (!skip_cur) begin
            result_d[sel_q] = bus.alu_op;
            sig_d           = sig_next;
          end
          if (sel_q == 4'hF) begin
            state_d = FIN;
            sel_d   = 4'd0;
          end else begin
            sel_d = sel_q + 4'd1;
          end
        end else begin
          dwell_d = dwell_q + 4'd1;
        end
      end

      FIN: begin
        // start is not looked at here; a new sweep can only begin from IDLE.
        pass_d  = sig_match;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over any pending start.
  // NOTE: sequential blocks use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers, including the result table.
  // NOTE: the result table is reset explicitly because reset must read
  // back as all zeros; that is why it lives in flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      sel_q   <= 4'd0;
      dwell_q <= 4'd0;
      sig_q   <= 16'h0000;
      pass_q  <= 1'b0;
      for (int i = 0; i < 16; i++) result_q[i] <= 16'h0000;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      dwell_q  <= dwell_d;
      sig_q    <= sig_d;
      pass_q   <= pass_d;
      result_q <= result_d;
    end
  end

  // pass is shown live during FIN so it is valid alongside done, then
  // held from the register until the next accepted start.
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_sel   = sel_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FIN);
  assign bus.pass      = (state_q == FIN) ? sig_match : pass_q;
  assign bus.signature = sig_q;
  assign bus.rd_data   = result_q[bus.rd_addr];

endmodule

// File: tb/tb_alu_sweeper.sv
// Testbench for alu_sweeper: three instances (no skips, opcode 4 skipped,
// all opcodes skipped) share stimulus; each has its own ALU model.
module tb_alu_sweeper;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  a_in;
  logic [3:0]  b_in;
  logic [3:0]  rd_addr;
  logic [15:0] exp0, exp1, exp2;

  int n_checks = 0;
  int n_fail   = 0;

  alu_sweeper_if bus0 ();
  alu_sweeper_if bus1 ();
  alu_sweeper_if bus2 ();

  alu_sweeper #(.DWELL(2), .SKIP_MASK(16'h0000)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  alu_sweeper #(.DWELL(2), .SKIP_MASK(16'h0010)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  alu_sweeper #(.DWELL(2), .SKIP_MASK(16'hFFFF)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  assign bus0.start = start;  assign bus1.start = start;  assign bus2.start = start;
  assign bus0.a_in  = a_in;   assign bus1.a_in  = a_in;   assign bus2.a_in  = a_in;
  assign bus0.b_in  = b_in;   assign bus1.b_in  = b_in;   assign bus2.b_in  = b_in;
  assign bus0.rd_addr = rd_addr; assign bus1.rd_addr = rd_addr; assign bus2.rd_addr = rd_addr;
  assign bus0.exp_sig = exp0; assign bus1.exp_sig = exp1; assign bus2.exp_sig = exp2;

  // ALU models: op = {sel, a, b, a ^ b}
  assign bus0.alu_op = {bus0.alu_sel, bus0.alu_a, bus0.alu_b, bus0.alu_a ^ bus0.alu_b};
  assign bus1.alu_op = {bus1.alu_sel, bus1.alu_a, bus1.alu_b, bus1.alu_a ^ bus1.alu_b};
  assign bus2.alu_op = {bus2.alu_sel, bus2.alu_a, bus2.alu_b, bus2.alu_a ^ bus2.alu_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_sig(input logic [3:0] a, input logic [3:0] b,
                                            input logic [15:0] mask);
    logic [15:0] s;
    logic [3:0]  op_sel;
    s = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      op_sel = 4'(k);
      if (!mask[k]) s = {s[14:0], s[15]} ^ {op_sel, a, b, a ^ b};
    end
    return s;
  endfunction

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } rd_vec_t;

  rd_vec_t rd_vecs [5];

  // Per-sweep observations
  int run0, run1, run2, sel_err, sel4_cnt, a_err;
  bit d0, d1, d2, p0, p1, p2;

  // Pulse start with a=D, b=3 and observe up to 40 cycles. repulse_at
  // re-asserts start (with a_in=0) at that RUN cycle; rst_at asserts rst.
  task automatic do_sweep(input int repulse_at, input int rst_at);
    run0 = 0; run1 = 0; run2 = 0; sel_err = 0; sel4_cnt = 0; a_err = 0;
    d0 = 0; d1 = 0; d2 = 0; p0 = 0; p1 = 0; p2 = 0;
    @(negedge clk);
    a_in = 4'hD; b_in = 4'h3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus0.done) begin
        d0 = 1; p0 = bus0.pass;
      end else if (bus0.busy) begin
        run0++;
        if (bus0.alu_sel !== 4'((run0 - 1) / 2)) sel_err++;
        if (bus0.alu_a !== 4'hD) a_err++;
      end
      if (bus1.done) begin
        d1 = 1; p1 = bus1.pass;
      end else if (bus1.busy) begin
        run1++;
        if (bus1.alu_sel == 4'd4) sel4_cnt++;
      end
      if (bus2.done) begin
        d2 = 1; p2 = bus2.pass;
      end else if (bus2.busy) begin
        run2++;
      end
      if (cyc == repulse_at) begin
        start = 1'b1; a_in = 4'h0;
      end else if (cyc == repulse_at + 1) begin
        start = 1'b0;
      end
      if (cyc == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] good_sig;
    int rd_err;
    bit late_done;

    rst = 1'b1; start = 1'b0; a_in = 4'h0; b_in = 4'h0; rd_addr = 4'h0;
    exp0 = 16'h0; exp1 = 16'h0; exp2 = 16'h0;

    rd_vecs[0] = '{4'h0, 16'h0D3E, 16'h0D3E, 16'h0000};
    rd_vecs[1] = '{4'h4, 16'h4D3E, 16'h0000, 16'h0000};
    rd_vecs[2] = '{4'h5, 16'h5D3E, 16'h5D3E, 16'h0000};
    rd_vecs[3] = '{4'h9, 16'h9D3E, 16'h9D3E, 16'h0000};
    rd_vecs[4] = '{4'hF, 16'hFD3E, 16'hFD3E, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", bus0.busy, 0);
    check("rst_done", bus0.done, 0);
    check("rst_pass", bus0.pass, 0);
    check("rst_sig", bus0.signature, 0);
    check("rst_alu_a", bus0.alu_a, 0);
    check("rst_alu_sel", bus0.alu_sel, 0);
    check("rst_rd0", bus0.rd_data, 0);
    rst = 1'b0;

    // Full sweep, matching expected signatures
    good_sig = model_sig(4'hD, 4'h3, 16'h0000);
    exp0 = good_sig;
    exp1 = model_sig(4'hD, 4'h3, 16'h0010);
    exp2 = 16'h0000;
    do_sweep(0, 0);
    check("s1_done0", d0, 1);
    check("s1_done1", d1, 1);
    check("s1_done2", d2, 1);
    check("s1_run0", run0, 32);
    check("s1_run1", run1, 31);
    check("s1_run2", run2, 16);
    check("s1_sel_seq", sel_err, 0);
    check("s1_skip4_cycles", sel4_cnt, 1);
    check("s1_pass0", p0, 1);
    check("s1_pass1", p1, 1);
    check("s1_pass2", p2, 1);
    check("s1_sig0", bus0.signature, good_sig);
    check("s1_sig1", bus1.signature, exp1);
    check("s1_sig2", bus2.signature, 16'h0000);
    check("s1_pass_held", bus0.pass, 1);
    check("s1_busy_after", bus0.busy, 0);
    for (int i = 0; i < 5; i++) begin
      rd_addr = rd_vecs[i].addr;
      #1;
      check($sformatf("s1_rd0[%0d]", rd_vecs[i].addr), bus0.rd_data, rd_vecs[i].exp0);
      check($sformatf("s1_rd1[%0d]", rd_vecs[i].addr), bus1.rd_data, rd_vecs[i].exp1);
      check($sformatf("s1_rd2[%0d]", rd_vecs[i].addr), bus2.rd_data, rd_vecs[i].exp2);
    end

    // Wrong expected signature
    exp0 = good_sig ^ 16'h0001;
    do_sweep(0, 0);
    check("s2_done0", d0, 1);
    check("s2_pass0", p0, 0);
    check("s2_sig0", bus0.signature, good_sig);
    check("s2_pass_held", bus0.pass, 0);

    // start re-pulsed mid-sweep with a_in changed
    exp0 = good_sig;
    do_sweep(7, 0);
    check("s3_alu_a_stable", a_err, 0);
    check("s3_run0", run0, 32);
    check("s3_sel_seq", sel_err, 0);
    check("s3_sig0", bus0.signature, good_sig);
    check("s3_pass0", p0, 1);
    rd_err = 0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      if (bus0.rd_data !== {4'(i), 4'hD, 4'h3, 4'hE}) rd_err++;
    end
    check("s3_results", rd_err, 0);

    // Reset at RUN cycle 10
    do_sweep(0, 10);
    check("s4_busy", bus0.busy, 0);
    check("s4_sel", bus0.alu_sel, 0);
    check("s4_sig", bus0.signature, 0);
    check("s4_done", bus0.done, 0);
    check("s4_run_before_rst", run0, 10);
    rd_err = 0;
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      if (bus0.rd_data !== 16'h0000) rd_err++;
    end
    check("s4_results_clear", rd_err, 0);
    late_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus0.done || bus0.busy) late_done = 1;
    end
    check("s4_no_done", late_done | d0, 0);

    // Fresh sweep after reset
    do_sweep(0, 0);
    check("s5_done0", d0, 1);
    check("s5_run0", run0, 32);
    check("s5_sel_seq", sel_err, 0);
    check("s5_sig0", bus0.signature, good_sig);
    check("s5_pass0", p0, 1);

    // rst and start together
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a_in = 4'h5;
    @(negedge clk);
    check("s6_busy_rst", bus0.busy, 0);
    check("s6_alu_a_rst", bus0.alu_a, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("s6_busy_after", bus0.busy, 0);
    check("s6_pass_cleared", bus0.pass, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
